// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared types for the hazard/forwarding controller: forwarding select encodings,
// the per-stage tracking entry and helpers that evaluate all three stages at once.
package hazard_forward_ctrl_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int NUM_STAGES = 3;

  // Stage index order inside the tracking vector: 0 = ex, 1 = mem, 2 = wb
  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;

  localparam logic [NUM_STAGES-1:0] EX_ONLY_MASK   = 3'b001;
  localparam logic [NUM_STAGES-1:0] EX_OR_MEM_MASK = 3'b011;

  typedef enum logic [1:0] {
    FWD_SEL_REG   = 2'b00,
    FWD_SEL_EXMEM = 2'b01,
    FWD_SEL_MEMWB = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } stage_entry_t;

  typedef stage_entry_t [NUM_STAGES-1:0] stage_vec_t;

  // One bit per stage: the source is read and that stage will write it.
  function automatic logic [NUM_STAGES-1:0] src_hits(
    input logic                  uses,
    input logic [REG_ADDR_W-1:0] rs,
    input stage_vec_t            st
  );
    logic [NUM_STAGES-1:0] h;
    h = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      h[i] = uses & st[i].valid & st[i].reg_write & (st[i].rd == rs);
    end
    return h;
  endfunction

  function automatic logic [NUM_STAGES-1:0] load_bits(input stage_vec_t st);
    logic [NUM_STAGES-1:0] l;
    l = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      l[i] = st[i].mem_read;
    end
    return l;
  endfunction

  // Nearest producer wins; a wb hit means the register file already has the value.
  function automatic fwd_sel_e pick_sel(input logic [NUM_STAGES-1:0] h);
    fwd_sel_e s;
    s = FWD_SEL_REG;
    casez (h)
      3'b??1:  s = FWD_SEL_EXMEM;
      3'b?10:  s = FWD_SEL_MEMWB;
      default: s = FWD_SEL_REG;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hazard_forward_ctrl_stage_entry.sv
// One pipeline tracking entry: async-reset valid bit plus destination metadata.
// A bubble load clears valid; the metadata fields are don't-care once valid is 0.
module hazard_stage_entry
  import hazard_forward_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         bubble,
  input  stage_entry_t d,
  output stage_entry_t q
);

  logic                  vld_p1;
  logic [REG_ADDR_W-1:0] rd_p1;
  logic                  reg_write_p1;
  logic                  mem_read_p1;

  // stage boundary: entry register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= d.valid & ~bubble;
    end
  end

  always_ff @(posedge clk) begin
    rd_p1        <= d.rd;
    reg_write_p1 <= d.reg_write;
    mem_read_p1  <= d.mem_read;
  end

  assign q.valid     = vld_p1;
  assign q.rd        = rd_p1;
  assign q.reg_write = reg_write_p1;
  assign q.mem_read  = mem_read_p1;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Load-use stall and EX operand forwarding control for a 5-stage pipeline.
// Define HAZARD_FORWARD_EN for forwarding; otherwise any ex/mem dependency stalls.
module hazard_forward_ctrl
  import hazard_forward_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic [1:0]            aluInputAForwardingSel,
  output logic [1:0]            aluInputBForwardingSel,
  output logic                  stall,
  output logic [15:0]           stall_count
);

  stage_vec_t            stage_q;
  stage_entry_t          ex_d;
  logic                  ex_bubble;
  logic [NUM_STAGES-1:0] hits_a;
  logic [NUM_STAGES-1:0] hits_b;
  logic                  stall_cond;

  assign ex_d.valid     = id_valid;
  assign ex_d.rd        = id_rd;
  assign ex_d.reg_write = id_reg_write;
  assign ex_d.mem_read  = id_mem_read;

  assign ex_bubble = stall | flush;

  hazard_stage_entry u_ex (
    .clk    (clk),
    .rst    (rst),
    .bubble (ex_bubble),
    .d      (ex_d),
    .q      (stage_q[STG_EX])
  );

  hazard_stage_entry u_mem (
    .clk    (clk),
    .rst    (rst),
    .bubble (1'b0),
    .d      (stage_q[STG_EX]),
    .q      (stage_q[STG_MEM])
  );

  hazard_stage_entry u_wb (
    .clk    (clk),
    .rst    (rst),
    .bubble (1'b0),
    .d      (stage_q[STG_MEM]),
    .q      (stage_q[STG_WB])
  );

  assign hits_a = src_hits(id_uses_rs1, id_rs1, stage_q);
  assign hits_b = src_hits(id_uses_rs2, id_rs2, stage_q);

`ifdef HAZARD_FORWARD_EN
  fwd_sel_e sel_a_p0;
  fwd_sel_e sel_b_p0;
  logic [1:0] sel_a_p1;
  logic [1:0] sel_b_p1;

  // Only a load still in EX cannot be forwarded in time.
  assign stall_cond = |((hits_a | hits_b) & load_bits(stage_q) & EX_ONLY_MASK);

  always_comb begin
    sel_a_p0 = pick_sel(hits_a);
    sel_b_p0 = pick_sel(hits_b);
  end

  // stage boundary: decode -> EX select registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_a_p1 <= FWD_SEL_REG;
      sel_b_p1 <= FWD_SEL_REG;
    end else if (stall || flush) begin
      sel_a_p1 <= FWD_SEL_REG;
      sel_b_p1 <= FWD_SEL_REG;
    end else begin
      sel_a_p1 <= sel_a_p0;
      sel_b_p1 <= sel_b_p0;
    end
  end

  assign aluInputAForwardingSel = sel_a_p1;
  assign aluInputBForwardingSel = sel_b_p1;
`else
  // Without bypass paths the reader waits until the producer reaches WB.
  assign stall_cond = |((hits_a | hits_b) & EX_OR_MEM_MASK);

  assign aluInputAForwardingSel = FWD_SEL_REG;
  assign aluInputBForwardingSel = FWD_SEL_REG;
`endif

  // A flushed decode slot never stalls; reset masks stall regardless of inputs.
  assign stall = rst & id_valid & ~flush & stall_cond;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= 16'h0000;
    end else if (stall && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'h0001;
    end
  end

endmodule
